scale_sequencer: RTL and testbench

- Frame-synchronous controller for the `scale` coordinate-scaling datapath. It owns the 2-bit scale code that feeds `scale.scale_in`.
- Accepts scale-change requests from two requesters: a step pulse from the user button (already debounced) and a direct set from the motion/gesture logic.
- Arbitrates between them and holds the winner as pending. The pending value is applied only at the end-of-frame pixel, so the scaled image never tears mid-frame.
- Sits between the input/control logic and `scale`, on the pixel clock, alongside the video sig generator.

---
 rtl/scale_pkg.sv | 29 ++
 rtl/frame_boundary_detect.sv | 20 ++
 rtl/scale_sequencer.sv | 99 +++++++++
 tb/tb_scale_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared types and timing constants for the scale datapath and its sequencer.
package scale_pkg;

    // Scale code driven into scale.scale_in
    typedef enum logic [1:0] {
        SCALE_1X = 2'd0,
        SCALE_2X = 2'd1,
        SCALE_4X = 2'd2,
        SCALE_8X = 2'd3
    } scale_t;

    // Sequencer state: idle, or holding a request until the frame boundary
    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } seq_state_t;

    // Default 720p raster totals
    localparam int unsigned H_TOTAL_720P = 1650;
    localparam int unsigned V_TOTAL_720P = 750;

    // Next scale code, wrapping 3 -> 0 (no saturation)
    function automatic scale_t scale_inc(input scale_t s);
        logic [1:0] n;
        n = s + 2'd1;
        return scale_t'(n);
    endfunction

endpackage

// File: rtl/frame_boundary_detect.sv
// Flags the last pixel of a frame from the raster counters.
// Purely combinational so the flag lines up with the counters it was decoded from.
module frame_boundary_detect #(
    parameter int unsigned H_TOTAL = 1650,
    parameter int unsigned V_TOTAL = 750
) (
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic        boundary_out
);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    // Exact match only; out-of-range counter values never fire
    always_comb begin
        boundary_out = (hcount_in == H_LAST) && (vcount_in == V_LAST);
    end

endmodule

// File: rtl/scale_sequencer.sv
// Frame-synchronous owner of the scale code. Requests are arbitrated and held
// as a pending target, and only committed on the last pixel of a frame so the
// new code takes effect from the first pixel of the next frame.
module scale_sequencer
    import scale_pkg::*;
#(
    parameter int unsigned H_TOTAL     = H_TOTAL_720P,
    parameter int unsigned V_TOTAL     = V_TOTAL_720P,
    parameter logic [1:0]  RESET_SCALE = 2'b00
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic        step_in,
    input  logic        set_valid_in,
    input  logic [1:0]  set_scale_in,
    input  logic        lock_in,
    output logic [1:0]  scale_out,
    output logic        pending_out,
    output logic        scale_update_out
);

    seq_state_t state_q;
    scale_t     scale_q;
    scale_t     target_q;
    logic       update_q;

    logic       boundary;
    logic       request;
    logic       apply;
    scale_t     next_target;

    frame_boundary_detect #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_boundary (
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .boundary_out (boundary)
    );

    // Arbitrate requests: a set beats a same-cycle step; steps accumulate on
    // the pending target, or start from the live scale when nothing is pending
    always_comb begin
        request     = set_valid_in || step_in;
        apply       = (state_q == PENDING) && boundary && !lock_in;
        next_target = target_q;
        if (set_valid_in) begin
            next_target = scale_t'(set_scale_in);
        end else if (state_q == IDLE) begin
            next_target = scale_inc(scale_q);
        end else begin
            // After an apply scale_q becomes target_q, so target_q + 1 is also
            // correct for a step landing on the boundary cycle
            next_target = scale_inc(target_q);
        end
    end

    // Sequencer FSM with registered outputs; a boundary-cycle request is not
    // merged into the apply but becomes the target for the next frame
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= IDLE;
            scale_q  <= scale_t'(RESET_SCALE);
            target_q <= scale_t'(RESET_SCALE);
            update_q <= 1'b0;
        end else begin
            update_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (request) begin
                        target_q <= next_target;
                        state_q  <= PENDING;
                    end
                end
                PENDING: begin
                    if (apply) begin
                        scale_q  <= target_q;
                        update_q <= (target_q != scale_q);
                        state_q  <= request ? PENDING : IDLE;
                    end
                    if (request) begin
                        target_q <= next_target;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Drive outputs straight from state
    always_comb begin
        scale_out        = scale_q;
        pending_out      = (state_q == PENDING);
        scale_update_out = update_q;
    end

endmodule

// File: tb/tb_scale_sequencer.sv
// Directed bench for scale_sequencer on a reduced 500x300 raster. A behavioural
// model pushes the expected outputs for every clock into a queue; they are
// popped and compared once the DUT has clocked. Key points of each scenario are
// also checked against fixed constants.
module tb_scale_sequencer;

    localparam int unsigned HT = 500;
    localparam int unsigned VT = 300;

    typedef struct packed {
        logic [1:0] scale;
        logic       pending;
        logic       update;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        step;
    logic        set_valid;
    logic [1:0]  set_scale;
    logic        lock;
    logic [1:0]  scale_out;
    logic        pending_out;
    logic        scale_update_out;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [1:0] m_scale = 2'd0;
    logic [1:0] m_target = 2'd0;
    logic       m_pend = 1'b0;
    logic       m_upd = 1'b0;

    exp_t sb[$];

    always #5 clk = ~clk;

    scale_sequencer #(
        .H_TOTAL     (HT),
        .V_TOTAL     (VT),
        .RESET_SCALE (2'b00)
    ) dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .hcount_in        (hcount),
        .vcount_in        (vcount),
        .step_in          (step),
        .set_valid_in     (set_valid),
        .set_scale_in     (set_scale),
        .lock_in          (lock),
        .scale_out        (scale_out),
        .pending_out      (pending_out),
        .scale_update_out (scale_update_out)
    );

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply first, then take the new request, as the sequencer is defined
    task automatic model_step();
        logic bnd;
        exp_t e;
        if (rst) begin
            m_scale = 2'd0; m_target = 2'd0; m_pend = 1'b0; m_upd = 1'b0;
        end else begin
            bnd   = (hcount == 11'(HT - 1)) && (vcount == 10'(VT - 1));
            m_upd = 1'b0;
            if (m_pend && bnd && !lock) begin
                m_upd   = (m_target != m_scale);
                m_scale = m_target;
                m_pend  = 1'b0;
            end
            if (set_valid) begin
                m_target = set_scale;
                m_pend   = 1'b1;
            end else if (step) begin
                m_target = (m_pend ? m_target : m_scale) + 2'd1;
                m_pend   = 1'b1;
            end
        end
        e.scale = m_scale; e.pending = m_pend; e.update = m_upd;
        sb.push_back(e);
    endtask

    // One clock: predict, clock, compare, then advance the raster and drop pulses
    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_scale", scale_out, e.scale);
        check("sb_pending", {1'b0, pending_out}, {1'b0, e.pending});
        check("sb_update", {1'b0, scale_update_out}, {1'b0, e.update});
        step = 1'b0;
        set_valid = 1'b0;
        if (hcount == 11'(HT - 1)) begin
            hcount = 11'd0;
            vcount = (vcount == 10'(VT - 1)) ? 10'd0 : vcount + 10'd1;
        end else begin
            hcount = hcount + 11'd1;
        end
    endtask

    task automatic goto_px(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
    endtask

    task automatic do_set(input logic [1:0] s);
        set_valid = 1'b1;
        set_scale = s;
        tick();
    endtask

    // Jump to the last pixel of the frame and clock through it
    task automatic cross_boundary();
        goto_px(HT - 1, VT - 1);
        tick();
    endtask

    initial begin
        rst = 1'b1; step = 1'b0; set_valid = 1'b0; set_scale = 2'd0; lock = 1'b0;
        goto_px(0, 0);
        tick();
        tick();
        rst = 1'b0;
        check("rst_scale", scale_out, 2'd0);
        check("rst_pending", {1'b0, pending_out}, 2'd0);
        check("rst_update", {1'b0, scale_update_out}, 2'd0);

        // Single set, applied only at the frame boundary
        goto_px(10, 5);
        do_set(2'd2);
        check("set_pending", {1'b0, pending_out}, 2'd1);
        check("set_no_early", scale_out, 2'd0);
        repeat (4) tick();
        goto_px(HT - 3, VT - 1);
        repeat (3) tick();
        check("set_at_00_h", 2'(hcount), 2'd0);
        check("set_apply", scale_out, 2'd2);
        check("set_upd", {1'b0, scale_update_out}, 2'd1);
        check("set_pend_clr", {1'b0, pending_out}, 2'd0);
        tick();
        check("set_upd_one", {1'b0, scale_update_out}, 2'd0);

        // Accumulated steps with wrap: 3 + 3 = 2 mod 4
        goto_px(20, 20);
        do_set(2'd3);
        cross_boundary();
        check("acc_base", scale_out, 2'd3);
        goto_px(30, 30);
        step = 1'b1; tick();
        tick();
        step = 1'b1; tick();
        step = 1'b1; tick();
        cross_boundary();
        check("acc_wrap", scale_out, 2'd2);

        // Same-cycle set beats step
        goto_px(40, 40);
        do_set(2'd0);
        cross_boundary();
        check("prio_base", scale_out, 2'd0);
        goto_px(50, 50);
        step = 1'b1; set_valid = 1'b1; set_scale = 2'd1;
        tick();
        cross_boundary();
        check("prio_set", scale_out, 2'd1);

        // Request on the boundary cycle goes to the following frame
        do_set(2'd0);
        cross_boundary();
        goto_px(0, 0);
        do_set(2'd1);
        goto_px(HT - 1, VT - 1);
        do_set(2'd3);
        check("bnd_frame1", scale_out, 2'd1);
        check("bnd_still_pend", {1'b0, pending_out}, 2'd1);
        cross_boundary();
        check("bnd_frame2", scale_out, 2'd3);
        check("bnd_pend_clr", {1'b0, pending_out}, 2'd0);

        // Set equal to current scale: pending clears, no update pulse
        goto_px(60, 60);
        do_set(2'd3);
        check("same_pend", {1'b0, pending_out}, 2'd1);
        cross_boundary();
        check("same_scale", scale_out, 2'd3);
        check("same_no_upd", {1'b0, scale_update_out}, 2'd0);
        check("same_pend_clr", {1'b0, pending_out}, 2'd0);

        // Lock holds the target across two boundaries
        goto_px(70, 70);
        do_set(2'd2);
        lock = 1'b1;
        cross_boundary();
        cross_boundary();
        check("lock_hold", scale_out, 2'd3);
        check("lock_pend", {1'b0, pending_out}, 2'd1);
        lock = 1'b0;
        goto_px(80, 80);
        tick();
        cross_boundary();
        check("lock_release", scale_out, 2'd2);
        check("lock_upd", {1'b0, scale_update_out}, 2'd1);

        // Reset mid-frame discards the pending request
        goto_px(90, 90);
        do_set(2'd3);
        goto_px(200, 100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_scale", scale_out, 2'd0);
        check("mid_rst_pend", {1'b0, pending_out}, 2'd0);
        cross_boundary();
        check("mid_rst_nochg", scale_out, 2'd0);
        check("mid_rst_no_upd", {1'b0, scale_update_out}, 2'd0);

        // Near-miss counter values never apply
        goto_px(10, 10);
        do_set(2'd1);
        goto_px(HT - 1, VT - 2);
        tick();
        goto_px(HT - 2, VT - 1);
        tick();
        goto_px(HT - 1, VT);
        tick();
        check("near_miss", scale_out, 2'd0);
        check("near_pend", {1'b0, pending_out}, 2'd1);
        cross_boundary();
        check("near_apply", scale_out, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
